fft_bin_peak: RTL and testbench



---
 rtl/fft_pkg.sv | 11 +
 rtl/cmag2_reg.sv | 35 +++
 rtl/fft_bin_peak.sv | 151 +++++++++++++++
 tb/tb_fft_bin_peak.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sizing constants and sample/magnitude types
package fft_pkg;
  localparam int N    = 256;
  localparam int LOGN = 8;
  localparam int DW   = 16;
  localparam int MW   = 2 * DW;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic [MW-1:0]        mag2_t;
  typedef logic [LOGN-1:0]      bin_t;
endpackage

// File: rtl/cmag2_reg.sv
// rtl/cmag2_reg.sv - registered complex magnitude-squared, 1-cycle latency
module cmag2_reg
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  sample_t i_re,
  input  sample_t i_im,
  output logic    o_valid,
  output mag2_t   o_mag2
);
  logic signed [MW-1:0] w_re_ext;
  logic signed [MW-1:0] w_im_ext;
  logic signed [MW-1:0] w_re2;
  logic signed [MW-1:0] w_im2;

  // Each square is at most 2^30 so the unsigned sum (max 2^31) always fits in MW bits
  assign w_re_ext = MW'(i_re);
  assign w_im_ext = MW'(i_im);
  assign w_re2    = w_re_ext * w_re_ext;
  assign w_im2    = w_im_ext * w_im_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_mag2  <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_mag2 <= $unsigned(w_re2) + $unsigned(w_im2);
      end
    end
  end
endmodule

// File: rtl/fft_bin_peak.sv
// rtl/fft_bin_peak.sv - per-frame peak bin search and selected-bin capture
module fft_bin_peak
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t y_re,
  input  sample_t y_im,
  input  logic    y_valid,
  input  logic    y_last,
  input  bin_t    sel_bin,
  input  logic    search_half,
  output bin_t    pk_bin,
  output mag2_t   pk_mag2,
  output sample_t sel_re,
  output sample_t sel_im,
  output logic    res_valid,
  output logic    frame_err
);
  bin_t    r_cnt;
  bin_t    r_sel_lat;
  logic    r_half_lat;

  logic    w_first;
  logic    w_at_end;
  bin_t    w_sel;
  logic    w_half;

  logic    w_s1_valid;
  mag2_t   w_s1_mag2;
  bin_t    r1_bin;
  sample_t r1_re;
  sample_t r1_im;
  logic    r1_first;
  logic    r1_in_range;
  logic    r1_sel_hit;
  logic    r1_end;
  logic    r1_err;

  bin_t    r_run_bin;
  mag2_t   r_run_mag;
  sample_t r_run_re;
  sample_t r_run_im;
  bin_t    w_nxt_bin;
  mag2_t   w_nxt_mag;
  sample_t w_nxt_re;
  sample_t w_nxt_im;

  // Bin 0 uses the live controls so its own select/range decision sees this frame's settings
  assign w_first  = (r_cnt == '0);
  assign w_at_end = (r_cnt == bin_t'(N - 1));
  assign w_sel    = w_first ? sel_bin : r_sel_lat;
  assign w_half   = w_first ? search_half : r_half_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_sel_lat  <= '0;
      r_half_lat <= 1'b0;
    end else if (y_valid) begin
      r_cnt <= y_last ? '0 : r_cnt + 1'b1;
      if (w_first) begin
        r_sel_lat  <= sel_bin;
        r_half_lat <= search_half;
      end
    end
  end

  cmag2_reg u_cmag2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (y_valid),
    .i_re    (y_re),
    .i_im    (y_im),
    .o_valid (w_s1_valid),
    .o_mag2  (w_s1_mag2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_bin      <= '0;
      r1_re       <= '0;
      r1_im       <= '0;
      r1_first    <= 1'b0;
      r1_in_range <= 1'b0;
      r1_sel_hit  <= 1'b0;
      r1_end      <= 1'b0;
      r1_err      <= 1'b0;
    end else if (y_valid) begin
      r1_bin      <= r_cnt;
      r1_re       <= y_re;
      r1_im       <= y_im;
      r1_first    <= w_first;
      r1_in_range <= !(w_half && r_cnt[LOGN-1]);
      r1_sel_hit  <= (r_cnt == w_sel);
      r1_end      <= y_last && w_at_end;
      r1_err      <= y_last ^ w_at_end;
    end
  end

  // Strict compare keeps the earliest bin on ties
  always_comb begin
    w_nxt_bin = r_run_bin;
    w_nxt_mag = r_run_mag;
    w_nxt_re  = r_run_re;
    w_nxt_im  = r_run_im;
    if (r1_first || (r1_in_range && (w_s1_mag2 > r_run_mag))) begin
      w_nxt_bin = r1_bin;
      w_nxt_mag = w_s1_mag2;
    end
    if (r1_sel_hit) begin
      w_nxt_re = r1_re;
      w_nxt_im = r1_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_bin <= '0;
      r_run_mag <= '0;
      r_run_re  <= '0;
      r_run_im  <= '0;
      pk_bin    <= '0;
      pk_mag2   <= '0;
      sel_re    <= '0;
      sel_im    <= '0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      frame_err <= 1'b0;
      if (w_s1_valid) begin
        if (r1_err) begin
          frame_err <= 1'b1;
        end else begin
          r_run_bin <= w_nxt_bin;
          r_run_mag <= w_nxt_mag;
          r_run_re  <= w_nxt_re;
          r_run_im  <= w_nxt_im;
          if (r1_end) begin
            pk_bin    <= w_nxt_bin;
            pk_mag2   <= w_nxt_mag;
            sel_re    <= w_nxt_re;
            sel_im    <= w_nxt_im;
            res_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_bin_peak.sv
// tb/tb_fft_bin_peak.sv - self-checking bench for fft_bin_peak
module tb_fft_bin_peak;
  import fft_pkg::*;

  typedef struct {
    bin_t    bin;
    mag2_t   mag;
    sample_t re;
    sample_t im;
  } res_t;

  typedef struct {
    int      kind;
    bit      half;
    bin_t    sel;
    bin_t    eb;
    mag2_t   em;
    sample_t er;
    sample_t ei;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst;
  sample_t y_re;
  sample_t y_im;
  logic    y_valid;
  logic    y_last;
  bin_t    sel_bin;
  logic    search_half;
  bin_t    pk_bin;
  mag2_t   pk_mag2;
  sample_t sel_re;
  sample_t sel_im;
  logic    res_valid;
  logic    frame_err;

  fft_bin_peak dut (
    .clk         (clk),
    .rst         (rst),
    .y_re        (y_re),
    .y_im        (y_im),
    .y_valid     (y_valid),
    .y_last      (y_last),
    .sel_bin     (sel_bin),
    .search_half (search_half),
    .pk_bin      (pk_bin),
    .pk_mag2     (pk_mag2),
    .sel_re      (sel_re),
    .sel_im      (sel_im),
    .res_valid   (res_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  sample_t fr_re[N];
  sample_t fr_im[N];
  bin_t    cur_sel;
  bit      cur_half;
  res_t    got_q[$];
  res_t    exp_q[$];
  int      fe_cnt = 0;
  int      n_checks = 0;
  int      n_pass = 0;

  always @(negedge clk) begin
    if (res_valid) got_q.push_back('{pk_bin, pk_mag2, sel_re, sel_im});
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic fill_frame(input int kind);
    for (int k = 0; k < N; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
      if (kind == 3) begin
        fr_re[k] = sample_t'($urandom);
        fr_im[k] = sample_t'($urandom);
      end
    end
    case (kind)
      0: fr_re[0] = 16'sd8192;
      1: begin fr_im[8] = -16'sd16384; fr_im[248] = 16'sd16384; end
      2: begin fr_re[5] = 16'sh8000; fr_im[5] = 16'sh8000; end
      default: ;
    endcase
  endtask

  // Reference: brute-force scan of the stored frame, first strict maximum wins
  function automatic res_t model(input bit half, input bin_t sel);
    res_t   r;
    longint best = -1;
    longint m;
    int     bb = 0;
    int     lim = half ? N / 2 : N;
    for (int k = 0; k < lim; k++) begin
      m = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
      if (m > best) begin best = m; bb = k; end
    end
    r.bin = bin_t'(bb);
    r.mag = mag2_t'(best);
    r.re  = fr_re[sel];
    r.im  = fr_im[sel];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      y_valid = 1'b0;
      y_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbeats, input bit do_last, input bit gap,
                            input int chg_at, input bin_t chg_sel);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      y_valid     = 1'b1;
      y_re        = fr_re[i];
      y_im        = fr_im[i];
      y_last      = do_last && (i == nbeats - 1);
      sel_bin     = (chg_at >= 0 && i >= chg_at) ? chg_sel : cur_sel;
      search_half = cur_half;
      if (gap && i != nbeats - 1) begin
        @(negedge clk);
        y_valid = 1'b0;
        y_last  = 1'b0;
        y_re    = sample_t'($urandom);
      end
    end
  endtask

  task automatic drain(input string tag);
    res_t g;
    res_t e;
    chk({tag, " pulse count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " pk_bin"}, g.bin, e.bin);
      chk({tag, " pk_mag2"}, g.mag, e.mag);
      chk({tag, " sel_re"}, g.re, e.re);
      chk({tag, " sel_im"}, g.im, e.im);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outputs(input string tag, input res_t e);
    chk({tag, " pk_bin"}, pk_bin, e.bin);
    chk({tag, " pk_mag2"}, pk_mag2, e.mag);
    chk({tag, " sel_re"}, sel_re, e.re);
    chk({tag, " sel_im"}, sel_im, e.im);
  endtask

  vec_t vt[5];
  res_t last_exp;
  res_t zero_res;
  int   fe0;

  initial begin
    vt[0] = '{0, 1'b0, 8'd0,   8'd0, 32'd67108864,  16'sd8192,  16'sd0};
    vt[1] = '{1, 1'b1, 8'd248, 8'd8, 32'd268435456, 16'sd0,     16'sd16384};
    vt[2] = '{1, 1'b0, 8'd248, 8'd8, 32'd268435456, 16'sd0,     16'sd16384};
    vt[3] = '{2, 1'b0, 8'd5,   8'd5, 32'h8000_0000, 16'sh8000,  16'sh8000};
    vt[4] = '{1, 1'b0, 8'd8,   8'd8, 32'd268435456, 16'sd0,     -16'sd16384};
    zero_res = '{8'd0, 32'd0, 16'sd0, 16'sd0};

    rst = 1'b1; y_re = '0; y_im = '0; y_valid = 1'b0; y_last = 1'b0;
    sel_bin = '0; search_half = 1'b0; cur_sel = '0; cur_half = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk_outputs("reset", zero_res);
    chk("reset res_valid", res_valid, 0);
    chk("reset frame_err", frame_err, 0);

    // DC frame with exact pulse timing: low at E+0.5, high at E+1.5, low at E+2.5
    fill_frame(0);
    cur_sel = 8'd0; cur_half = 1'b0;
    send_frame(N, 1'b1, 1'b0, -1, '0);
    idle(1); chk("latency before", res_valid, 0);
    idle(1); chk("latency pulse", res_valid, 1);
    idle(1); chk("latency after", res_valid, 0);
    idle(2);
    got_q.delete();

    for (int v = 0; v < 5; v++) begin
      fill_frame(vt[v].kind);
      cur_sel  = vt[v].sel;
      cur_half = vt[v].half;
      send_frame(N, 1'b1, 1'b0, -1, '0);
      idle(4);
      last_exp = '{vt[v].eb, vt[v].em, vt[v].er, vt[v].ei};
      exp_q.push_back(last_exp);
      drain($sformatf("vec%0d", v));
    end

    // sel_bin changed mid-frame must not affect the current frame
    fill_frame(1);
    cur_sel = 8'd248; cur_half = 1'b0;
    send_frame(N, 1'b1, 1'b0, 10, 8'd8);
    idle(4);
    last_exp = '{8'd8, 32'd268435456, 16'sd0, 16'sd16384};
    exp_q.push_back(last_exp);
    drain("midsel");

    // Early y_last on beat 100
    fill_frame(3);
    fe0 = fe_cnt;
    send_frame(101, 1'b1, 1'b0, -1, '0);
    idle(4);
    chk("early last frame_err", fe_cnt - fe0, 1);
    drain("early last");
    chk_outputs("early last hold", last_exp);

    // Full-length frame missing y_last
    fill_frame(3);
    fe0 = fe_cnt;
    send_frame(N, 1'b0, 1'b0, -1, '0);
    idle(4);
    chk("missing last frame_err", fe_cnt - fe0, 1);
    drain("missing last");
    chk_outputs("missing last hold", last_exp);

    fill_frame(3);
    cur_sel = bin_t'($urandom); cur_half = 1'b1;
    exp_q.push_back(model(cur_half, cur_sel));
    send_frame(N, 1'b1, 1'b0, -1, '0);
    idle(4);
    drain("recovery");

    // Three back-to-back random frames then one gapped frame
    fe0 = fe_cnt;
    for (int f = 0; f < 4; f++) begin
      fill_frame(3);
      if (f == 0) fr_re[200] = 16'sh8000;
      cur_sel  = bin_t'($urandom);
      cur_half = 1'($urandom);
      exp_q.push_back(model(cur_half, cur_sel));
      send_frame(N, 1'b1, f == 3, -1, '0);
    end
    idle(4);
    chk("throughput frame_err", fe_cnt - fe0, 0);
    drain("throughput");

    // Tie across halves with random data elsewhere kept small
    for (int k = 0; k < N; k++) begin
      fr_re[k] = sample_t'($urandom_range(0, 100));
      fr_im[k] = '0;
    end
    fr_re[40] = 16'sd3000; fr_re[30] = -16'sd3000; fr_im[200] = 16'sd3000;
    cur_sel = 8'd200; cur_half = 1'b0;
    exp_q.push_back(model(cur_half, cur_sel));
    send_frame(N, 1'b1, 1'b0, -1, '0);
    idle(4);
    drain("tie");

    // Reset at beat 128 drops the frame and clears outputs
    fill_frame(3);
    fe0 = fe_cnt;
    send_frame(128, 1'b0, 1'b0, -1, '0);
    @(negedge clk);
    rst = 1'b1; y_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    chk("reset mid frame_err", fe_cnt - fe0, 0);
    drain("reset mid");
    chk_outputs("reset mid", zero_res);

    fill_frame(3);
    cur_sel = bin_t'($urandom); cur_half = 1'b0;
    exp_q.push_back(model(cur_half, cur_sel));
    send_frame(N, 1'b1, 1'b0, -1, '0);
    idle(4);
    drain("after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
